// File: rtl/axis_test_pattern_gen_if.sv
// AXI-Stream video bus carrying start-of-frame on tuser and end-of-line on tlast.
// The pattern generator drives the master side; the downstream consumer owns tready.
interface axis_test_pattern_gen_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  tuser;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [DATA_WIDTH-1:0] tdata;

  modport master (output tuser, output tvalid, output tlast, output tdata, input tready);
  modport slave  (input tuser, input tvalid, input tlast, input tdata, output tready);
endinterface

// File: rtl/axis_test_pattern_gen.sv
// Synthetic video source: emits whole frames (x, y, checker or frame-count patterns)
// with an optional idle gap between frames, fully honouring downstream backpressure.
module axis_test_pattern_gen #(
  parameter int IMG_WIDTH_MAX   = 16,
  parameter int IMG_HEIGHT_MAX  = 16,
  parameter int AXIS_DATA_WIDTH = 8
) (
  input  logic                      i_axi_clk,
  input  logic                      i_axi_rst,
  input  logic                      i_enable,
  input  logic [IMG_WIDTH_MAX-1:0]  i_width,
  input  logic [IMG_HEIGHT_MAX-1:0] i_height,
  input  logic [1:0]                i_pattern,
  input  logic [31:0]               i_frame_gap,
  axis_test_pattern_gen_if.master   axis_out,
  output logic [31:0]               o_frame_count,
  output logic                      o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_GAP} state_t;

  localparam logic [IMG_WIDTH_MAX-1:0]  X_ONE  = IMG_WIDTH_MAX'(1);
  localparam logic [IMG_HEIGHT_MAX-1:0] Y_ONE  = IMG_HEIGHT_MAX'(1);
  // Masks selecting coordinate bit 3; they collapse to zero on narrow counters.
  localparam logic [IMG_WIDTH_MAX-1:0]  X_BIT3 = IMG_WIDTH_MAX'(8);
  localparam logic [IMG_HEIGHT_MAX-1:0] Y_BIT3 = IMG_HEIGHT_MAX'(8);

  state_t                     r_state, w_state_next;
  logic [IMG_WIDTH_MAX-1:0]   r_x, w_x_next, r_w, w_w_next;
  logic [IMG_HEIGHT_MAX-1:0]  r_y, w_y_next, r_h, w_h_next;
  logic [1:0]                 r_pat, w_pat_next;
  logic [31:0]                r_gap, w_gap_next;
  logic [31:0]                r_gap_cnt, w_gap_cnt_next;
  logic [31:0]                r_frame_count, w_frame_count_next;
  logic                       r_tvalid, w_tvalid_next;
  logic                       r_tuser, w_tuser_next;
  logic                       r_tlast, w_tlast_next;
  logic [AXIS_DATA_WIDTH-1:0] r_tdata, w_tdata_next;
  logic                       r_busy, w_busy_next;

  logic        w_start_ok;
  logic        w_xfer;
  logic        w_last_x;
  logic        w_last_y;
  logic        w_do_start;
  logic [31:0] w_start_fc;

  function automatic logic [AXIS_DATA_WIDTH-1:0] f_pixel(
    input logic [IMG_WIDTH_MAX-1:0]  x,
    input logic [IMG_HEIGHT_MAX-1:0] y,
    input logic [1:0]                pat,
    input logic [31:0]               fc
  );
    logic [AXIS_DATA_WIDTH-1:0] pix;
    case (pat)
      2'd0:    pix = AXIS_DATA_WIDTH'(x);
      2'd1:    pix = AXIS_DATA_WIDTH'(y);
      2'd2:    pix = ((|(x & X_BIT3)) ^ (|(y & Y_BIT3))) ? '1 : '0;
      default: pix = AXIS_DATA_WIDTH'(fc);
    endcase
    return pix;
  endfunction

  always_ff @(posedge i_axi_clk) begin
    if (i_axi_rst) begin
      r_state       <= S_IDLE;
      r_x           <= '0;
      r_y           <= '0;
      r_w           <= '0;
      r_h           <= '0;
      r_pat         <= '0;
      r_gap         <= '0;
      r_gap_cnt     <= '0;
      r_frame_count <= '0;
      r_tvalid      <= 1'b0;
      r_tuser       <= 1'b0;
      r_tlast       <= 1'b0;
      r_tdata       <= '0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_x           <= w_x_next;
      r_y           <= w_y_next;
      r_w           <= w_w_next;
      r_h           <= w_h_next;
      r_pat         <= w_pat_next;
      r_gap         <= w_gap_next;
      r_gap_cnt     <= w_gap_cnt_next;
      r_frame_count <= w_frame_count_next;
      r_tvalid      <= w_tvalid_next;
      r_tuser       <= w_tuser_next;
      r_tlast       <= w_tlast_next;
      r_tdata       <= w_tdata_next;
      r_busy        <= w_busy_next;
    end
  end

  always_comb begin
    w_start_ok = i_enable && (i_width != '0) && (i_height != '0);
    w_xfer     = r_tvalid && axis_out.tready;
    w_last_x   = (r_x == r_w - X_ONE);
    w_last_y   = (r_y == r_h - Y_ONE);
    w_do_start = 1'b0;
    w_start_fc = r_frame_count;

    w_state_next       = r_state;
    w_x_next           = r_x;
    w_y_next           = r_y;
    w_w_next           = r_w;
    w_h_next           = r_h;
    w_pat_next         = r_pat;
    w_gap_next         = r_gap;
    w_gap_cnt_next     = r_gap_cnt;
    w_frame_count_next = r_frame_count;
    w_tvalid_next      = r_tvalid;
    w_tuser_next       = r_tuser;
    w_tlast_next       = r_tlast;
    w_tdata_next       = r_tdata;
    w_busy_next        = r_busy;

    case (r_state)
      S_IDLE: begin
        w_do_start = w_start_ok;
      end

      S_ACTIVE: begin
        if (w_xfer) begin
          if (w_last_x && w_last_y) begin
            w_frame_count_next = r_frame_count + 32'd1;
            w_start_fc         = r_frame_count + 32'd1;
            w_tvalid_next      = 1'b0;
            w_tuser_next       = 1'b0;
            w_tlast_next       = 1'b0;
            w_tdata_next       = '0;
            if (r_gap != 32'd0) begin
              w_state_next   = S_GAP;
              w_gap_cnt_next = r_gap - 32'd1;
            end else if (w_start_ok) begin
              w_do_start = 1'b1;
            end else begin
              w_state_next = S_IDLE;
              w_busy_next  = 1'b0;
            end
          end else begin
            w_x_next     = w_last_x ? '0 : r_x + X_ONE;
            w_y_next     = w_last_x ? r_y + Y_ONE : r_y;
            w_tuser_next = 1'b0;
            w_tlast_next = (w_x_next == r_w - X_ONE);
            w_tdata_next = f_pixel(w_x_next, w_y_next, r_pat, r_frame_count);
          end
        end
      end

      S_GAP: begin
        // The gap's final cycle doubles as the frame-boundary enable check.
        if (r_gap_cnt == 32'd0) begin
          if (w_start_ok) begin
            w_do_start = 1'b1;
          end else begin
            w_state_next = S_IDLE;
            w_busy_next  = 1'b0;
          end
        end else begin
          w_gap_cnt_next = r_gap_cnt - 32'd1;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    if (w_do_start) begin
      w_state_next  = S_ACTIVE;
      w_w_next      = i_width;
      w_h_next      = i_height;
      w_pat_next    = i_pattern;
      w_gap_next    = i_frame_gap;
      w_x_next      = '0;
      w_y_next      = '0;
      w_tvalid_next = 1'b1;
      w_tuser_next  = 1'b1;
      w_tlast_next  = (i_width == X_ONE);
      w_tdata_next  = f_pixel('0, '0, i_pattern, w_start_fc);
      w_busy_next   = 1'b1;
    end
  end

  assign axis_out.tvalid = r_tvalid;
  assign axis_out.tuser  = r_tuser;
  assign axis_out.tlast  = r_tlast;
  assign axis_out.tdata  = r_tdata;
  assign o_frame_count   = r_frame_count;
  assign o_busy          = r_busy;

endmodule

// File: tb/tb_axis_test_pattern_gen.sv
// Directed bench for axis_test_pattern_gen: frame contents, backpressure, gaps,
// disable/reset behaviour and degenerate geometries with hand-computed expectations.
module tb_axis_test_pattern_gen;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [15:0] width;
  logic [15:0] height;
  logic [1:0]  pattern;
  logic [31:0] frame_gap;
  logic [31:0] frame_count;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] b_data [256];
  logic       b_user [256];
  logic       b_last [256];
  int         b_cyc  [256];
  int         b_fc   [256];
  int         nb;
  logic       seen;

  axis_test_pattern_gen_if #(.DATA_WIDTH(8)) axis ();

  axis_test_pattern_gen #(
    .IMG_WIDTH_MAX   (16),
    .IMG_HEIGHT_MAX  (16),
    .AXIS_DATA_WIDTH (8)
  ) dut (
    .i_axi_clk     (clk),
    .i_axi_rst     (rst),
    .i_enable      (enable),
    .i_width       (width),
    .i_height      (height),
    .i_pattern     (pattern),
    .i_frame_gap   (frame_gap),
    .axis_out      (axis),
    .o_frame_count (frame_count),
    .o_busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Samples at negedges; rnd selects a fixed stall pattern on tready.
  task automatic collect(input int n, input bit rnd, input int budget);
    int         got;
    int         cyc;
    bit         stalled;
    logic [7:0] sd;
    logic       su;
    logic       sl;
    logic [15:0] rdy_pat;
    got     = 0;
    cyc     = 0;
    stalled = 0;
    sd      = '0;
    su      = 1'b0;
    sl      = 1'b0;
    rdy_pat = 16'b0110_1001_1100_1011;
    nb      = 0;
    while (got < n && cyc < budget) begin
      if (stalled)
        check("stall_hold", {axis.tvalid, axis.tuser, axis.tlast, axis.tdata},
              {1'b1, su, sl, sd});
      axis.tready = rnd ? rdy_pat[cyc[3:0]] : 1'b1;
      if (axis.tvalid && axis.tready) begin
        b_data[nb] = axis.tdata;
        b_user[nb] = axis.tuser;
        b_last[nb] = axis.tlast;
        b_cyc[nb]  = cyc;
        b_fc[nb]   = int'(frame_count);
        $display("beat %0d data=%02h user=%0b last=%0b cyc=%0d fc=%0d",
                 nb, axis.tdata, axis.tuser, axis.tlast, cyc, frame_count);
        nb++;
        got++;
        stalled = 0;
      end else if (axis.tvalid) begin
        stalled = 1;
        sd = axis.tdata;
        su = axis.tuser;
        sl = axis.tlast;
      end else begin
        stalled = 0;
      end
      @(negedge clk);
      cyc++;
    end
    axis.tready = 1'b1;
    check("beats_received", got, n);
  endtask

  task automatic watch_idle(input int n);
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (axis.tvalid) seen = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic configure(input logic [15:0] w, input logic [15:0] h,
                           input logic [1:0] p, input logic [31:0] g);
    width     = w;
    height    = h;
    pattern   = p;
    frame_gap = g;
  endtask

  initial begin
    rst         = 1'b1;
    enable      = 1'b0;
    axis.tready = 1'b1;
    configure(16'd0, 16'd0, 2'd0, 32'd0);
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_tvalid", axis.tvalid, 1'b0);
    check("rst_tuser", axis.tuser, 1'b0);
    check("rst_tlast", axis.tlast, 1'b0);
    check("rst_tdata", axis.tdata, 8'h00);
    check("rst_fc", frame_count, 32'd0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    $display("step: basic frame 4x2 pattern 0");

    // Basic frame: 4x2, pattern x, one-cycle enable pulse
    configure(16'd4, 16'd2, 2'd0, 32'd0);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    check("start_latency_tvalid", axis.tvalid, 1'b1);
    check("start_latency_tuser", axis.tuser, 1'b1);
    collect(8, 1'b0, 50);
    check("basic_d0", b_data[0], 8'd0);
    check("basic_d1", b_data[1], 8'd1);
    check("basic_d3", b_data[3], 8'd3);
    check("basic_d4", b_data[4], 8'd0);
    check("basic_d7", b_data[7], 8'd3);
    check("basic_user0", b_user[0], 1'b1);
    check("basic_user4", b_user[4], 1'b0);
    check("basic_last2", b_last[2], 1'b0);
    check("basic_last3", b_last[3], 1'b1);
    check("basic_last7", b_last[7], 1'b1);
    check("basic_back2back", b_cyc[7] - b_cyc[0], 7);
    check("basic_fc", frame_count, 32'd1);
    check("basic_busy_off", busy, 1'b0);
    check("basic_idle_tvalid", axis.tvalid, 1'b0);
    watch_idle(5);
    check("basic_stays_idle", seen, 1'b0);
    $display("step: backpressure 3x3 pattern 1");

    // Backpressure: 3x3, pattern y, stalling tready
    configure(16'd3, 16'd3, 2'd1, 32'd0);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    collect(9, 1'b1, 100);
    check("bp_d0", b_data[0], 8'd0);
    check("bp_d2", b_data[2], 8'd0);
    check("bp_d3", b_data[3], 8'd1);
    check("bp_d5", b_data[5], 8'd1);
    check("bp_d6", b_data[6], 8'd2);
    check("bp_d8", b_data[8], 8'd2);
    check("bp_user0", b_user[0], 1'b1);
    check("bp_last2", b_last[2], 1'b1);
    check("bp_last5", b_last[5], 1'b1);
    check("bp_last8", b_last[8], 1'b1);
    check("bp_last4", b_last[4], 1'b0);
    check("bp_fc", frame_count, 32'd2);
    check("bp_busy_off", busy, 1'b0);
    $display("step: frame gap 2x2 G=5");

    // Frame gap: 2x2, G=5, enable held high across three frames
    configure(16'd2, 16'd2, 2'd0, 32'd5);
    enable = 1'b1;
    collect(12, 1'b0, 100);
    enable = 1'b0;
    check("gap_spacing_1", b_cyc[4] - b_cyc[3], 6);
    check("gap_spacing_2", b_cyc[8] - b_cyc[7], 6);
    check("gap_inframe", b_cyc[3] - b_cyc[0], 3);
    check("gap_user4", b_user[4], 1'b1);
    check("gap_user8", b_user[8], 1'b1);
    check("gap_fc_f0", b_fc[0], 2);
    check("gap_fc_f1", b_fc[4], 3);
    check("gap_fc_f2", b_fc[8], 4);
    check("gap_fc_after", frame_count, 32'd5);
    check("gap_busy_in_gap", busy, 1'b1);
    check("gap_tvalid_in_gap", axis.tvalid, 1'b0);
    repeat (6) @(negedge clk);
    check("gap_busy_end", busy, 1'b0);
    check("gap_tvalid_end", axis.tvalid, 1'b0);
    $display("step: disable mid-frame 8x4");

    // Disable mid-frame: 8x4, enable dropped at beat 10
    configure(16'd8, 16'd4, 2'd0, 32'd0);
    enable = 1'b1;
    collect(10, 1'b0, 50);
    enable = 1'b0;
    collect(22, 1'b0, 100);
    check("dis_beat10", b_data[0], 8'd2);
    check("dis_beat10_user", b_user[0], 1'b0);
    check("dis_beat15_last", b_last[5], 1'b1);
    check("dis_beat31", b_data[21], 8'd7);
    check("dis_beat31_last", b_last[21], 1'b1);
    check("dis_fc", frame_count, 32'd6);
    check("dis_busy_off", busy, 1'b0);
    watch_idle(10);
    check("dis_no_more_frames", seen, 1'b0);
    $display("step: reset mid-frame 8x8");

    // Reset mid-frame: 8x8, reset at beat 5
    configure(16'd8, 16'd8, 2'd0, 32'd0);
    enable = 1'b1;
    collect(5, 1'b0, 50);
    check("rmf_beat5", axis.tdata, 8'd5);
    rst = 1'b1;
    @(negedge clk);
    check("rmf_tvalid", axis.tvalid, 1'b0);
    check("rmf_fc", frame_count, 32'd0);
    check("rmf_busy", busy, 1'b0);
    check("rmf_tuser", axis.tuser, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("rmf_restart_tvalid", axis.tvalid, 1'b1);
    check("rmf_restart_tuser", axis.tuser, 1'b1);
    check("rmf_restart_tdata", axis.tdata, 8'd0);
    enable = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    $display("step: degenerate geometry and patterns");

    // Zero width: never starts
    configure(16'd0, 16'd4, 2'd0, 32'd0);
    enable = 1'b1;
    watch_idle(20);
    check("w0_no_tvalid", seen, 1'b0);
    check("w0_busy", busy, 1'b0);

    // W=1, H=3, pattern y
    configure(16'd1, 16'd3, 2'd1, 32'd0);
    @(negedge clk);
    enable = 1'b0;
    collect(3, 1'b0, 20);
    check("w1_last0", b_last[0], 1'b1);
    check("w1_last1", b_last[1], 1'b1);
    check("w1_last2", b_last[2], 1'b1);
    check("w1_user0", b_user[0], 1'b1);
    check("w1_user1", b_user[1], 1'b0);
    check("w1_d2", b_data[2], 8'd2);
    check("w1_fc", frame_count, 32'd1);

    // Pattern 2 checkerboard, 16x16
    configure(16'd16, 16'd16, 2'd2, 32'd0);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    collect(256, 1'b0, 400);
    for (int i = 0; i < 256; i++) begin
      int x;
      int y;
      x = i % 16;
      y = i / 16;
      check($sformatf("chk_x%0d_y%0d", x, y), b_data[i],
            ((x >= 8) != (y >= 8)) ? 8'hFF : 8'h00);
    end
    check("chk_fc", frame_count, 32'd2);

    // Pattern 3 frame count, W=2, H=1
    configure(16'd2, 16'd1, 2'd3, 32'd0);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    collect(2, 1'b0, 20);
    check("fcpat_d0", b_data[0], 8'd2);
    check("fcpat_d1", b_data[1], 8'd2);
    check("fcpat_user0", b_user[0], 1'b1);
    check("fcpat_last0", b_last[0], 1'b0);
    check("fcpat_last1", b_last[1], 1'b1);
    check("fcpat_fc", frame_count, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
